axi_revision_reader: RTL and testbench
======================================

Name: axi_revision_reader

Overview:
- AXI4-Lite read-only master that sits directly downstream of the build-revision register slave.
- On a start pulse it reads all 13 revision registers: major, minor, build, release candidate, date, RTL type, RTL subtype, build time, and git-hash words 0-4.
- It latches the values into parallel output registers for local logic (status LEDs, bring-up checks, version gating).
- Write channels are tied off; only AR/R are driven.

Parameters:
- BASE_ADDR, 0, byte address of the revision slave's register 0 (multiple of 4).
- AW, 7, AXI address width.

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- start  in  1  single-cycle request to (re)read all registers
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the sequence completes
- info_valid  out  1  outputs hold a complete, coherent snapshot
- resp_err  out  1  sticky: at least one RRESP!=OKAY in the last sequence
- ver_major, ver_minor, ver_build, ver_rcand, build_date, build_time, rtl_type, rtl_subtype  out  32 each  captured values
- git_hash  out  160  word0 in [159:128] ... word4 in [31:0]
- M_AXI_ARADDR  out  AW  read address
- M_AXI_ARVALID  out  1
- M_AXI_ARPROT  out  3  constant 0
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1
- M_AXI_AWADDR/AWVALID/AWPROT/WDATA/WSTRB/WVALID  out  all 0
- M_AXI_BREADY  out  1  constant 1

Behaviour:
- Reset (async on AXI_ARESETN=0):
  - state=IDLE; ARVALID=0, RREADY=0, busy=0, done=0, info_valid=0, resp_err=0.
  - All data outputs = 0; ARADDR = 0.
  - Reset mid-sequence abandons the sequence immediately; no partial data is retained.
- Read sequence: fixed register-index list 0,1,2,3,4,5,6,7,16,17,18,19,20. ARADDR = BASE_ADDR + 4*index, truncated to AW bits.
- FSM states IDLE, ADDR, DATA, DONE:
  - IDLE: on start=1 → clear info_valid and resp_err, set busy, seq_idx=0, go to ADDR. start while not IDLE is ignored.
  - ADDR: ARVALID=1, ARADDR stable. On ARVALID&ARREADY → ARVALID=0, RREADY=1, go to DATA. ARVALID is never withdrawn before the handshake.
  - DATA: RREADY=1. On RVALID&RREADY → capture RDATA into the target for seq_idx, set resp_err if RRESP!=0, RREADY=0.
    - If seq_idx=12 → DONE.
    - Else seq_idx+1 → ADDR.
  - DONE (one cycle): done=1, info_valid=1, busy=0, return to IDLE.
- RDATA is captured even on an error response; the data is stored as returned (DECERR → 0 from a compliant slave).
- Outputs change only at their own capture cycle. info_valid low during a sequence marks the snapshot incoherent.
- Timing:
  - ARVALID rises the cycle after start is sampled.
  - Minimum per-register cost is 2 cycles with a zero-wait slave: AR handshake cycle, then R handshake in the next cycle or later.
  - The next ARVALID follows the R handshake by 1 cycle.
- RVALID arriving while in ADDR is not accepted (RREADY=0); the slave holds it.
- ARREADY held low indefinitely → the block waits indefinitely. No timeout.
- start in the same cycle as done → ignored; a new start is accepted from the next IDLE cycle.
- Only one outstanding read at any time.

Test Plan:
- Zero-wait slave model returning MAJOR=1, MINOR=2, BUILD=3, RCAND=0, DATE=0x06052025, TIME=0x00143000, TYPE=5, SUBTYPE=6, HASH words 0x11111111..0x55555555, start pulse →
  - 13 AR handshakes at addresses 0x00,0x04,...,0x1C,0x40..0x50, in order;
  - outputs match;
  - git_hash=0x11111111_22222222_33333333_44444444_55555555;
  - done one pulse; info_valid=1; resp_err=0.
- ARREADY delayed 5 cycles and RVALID delayed 3 cycles per read →
  - ARVALID and ARADDR stable throughout each wait;
  - RREADY low until the AR handshake;
  - same captured values as the zero-wait run.
- Slave returns RRESP=DECERR, RDATA=0 for index 16 only → git_hash[159:128]=0, resp_err=1, all other fields correct, done asserted.
- Second start pulse after completion with MINOR changed to 9 →
  - info_valid drops the cycle after start;
  - ver_minor=9 at completion;
  - resp_err cleared from the previous run.
- start re-asserted while busy (at index 4) → no restart; exactly 13 reads total.
- AXI_ARESETN pulsed low during DATA for index 7 →
  - ARVALID/RREADY/busy/info_valid = 0 immediately;
  - outputs 0;
  - after release, a fresh start completes normally.

Source files
------------

// File: rtl/axi_revision_reader.sv
// axi_revision_reader
// AXI4-Lite read-only master that walks the build-revision slave's register map
// (indices 0..7 and 16..20) on a start pulse and latches every word into
// parallel output registers. Only AR/R are driven; write channels are idle.
//
// Handshake semantics: a channel transfers on a rising clock edge where both
// VALID and READY are high. ARVALID, once raised, is held with ARADDR stable
// until ARREADY is seen; RREADY is raised only after the AR handshake, so there
// is never more than one read outstanding.
module axi_revision_reader #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned AW        = 7
) (
  input  logic          AXI_ACLK,
  input  logic          AXI_ARESETN,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          info_valid,
  output logic          resp_err,
  output logic [31:0]   ver_major,
  output logic [31:0]   ver_minor,
  output logic [31:0]   ver_build,
  output logic [31:0]   ver_rcand,
  output logic [31:0]   build_date,
  output logic [31:0]   build_time,
  output logic [31:0]   rtl_type,
  output logic [31:0]   rtl_subtype,
  output logic [159:0]  git_hash,
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  output logic [2:0]    M_AXI_ARPROT,
  input  logic          M_AXI_ARREADY,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY,
  output logic [AW-1:0] M_AXI_AWADDR,
  output logic          M_AXI_AWVALID,
  output logic [2:0]    M_AXI_AWPROT,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  output logic          M_AXI_BREADY,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Position 12 is the last entry of the 13-read sequence.
  localparam logic [3:0] LAST_IDX = 4'd12;

  logic [1:0]  state;
  logic [3:0]  seq_idx;
  logic [31:0] snap [13];

  // Sequence position -> slave byte address. Positions 0..7 map to register
  // indices 0..7, positions 8..12 map to the git-hash block at 16..20.
  function automatic logic [AW-1:0] seq_addr(input logic [3:0] pos);
    logic [31:0] reg_index;
    logic [31:0] byte_addr;
    reg_index = (pos < 4'd8) ? {28'd0, pos} : ({28'd0, pos} + 32'd8);
    byte_addr = BASE_ADDR + (reg_index << 2);
    return byte_addr[AW-1:0];
  endfunction

  // Sequencer: issues one AR, waits for its R beat, captures it, repeats.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state         <= S_IDLE;
      seq_idx       <= 4'd0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      info_valid    <= 1'b0;
      resp_err      <= 1'b0;
      for (int i = 0; i < 13; i++) snap[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            info_valid    <= 1'b0;
            resp_err      <= 1'b0;
            busy          <= 1'b1;
            seq_idx       <= 4'd0;
            M_AXI_ARADDR  <= seq_addr(4'd0);
            M_AXI_ARVALID <= 1'b1;
            state         <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (M_AXI_RVALID) begin
            // Data is kept as returned, even on an error response.
            snap[seq_idx] <= M_AXI_RDATA;
            if (M_AXI_RRESP != 2'b00) resp_err <= 1'b1;
            M_AXI_RREADY <= 1'b0;
            if (seq_idx == LAST_IDX) begin
              done       <= 1'b1;
              info_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= S_DONE;
            end else begin
              seq_idx       <= seq_idx + 4'd1;
              M_AXI_ARADDR  <= seq_addr(seq_idx + 4'd1);
              M_AXI_ARVALID <= 1'b1;
              state         <= S_ADDR;
            end
          end
        end
        default: begin
          // S_DONE: one-cycle completion pulse; a start seen here is dropped.
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ver_major   = snap[0];
  assign ver_minor   = snap[1];
  assign ver_build   = snap[2];
  assign ver_rcand   = snap[3];
  assign build_date  = snap[4];
  assign rtl_type    = snap[5];
  assign rtl_subtype = snap[6];
  assign build_time  = snap[7];
  assign git_hash    = {snap[8], snap[9], snap[10], snap[11], snap[12]};

  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWADDR  = '0;
  assign M_AXI_AWVALID = 1'b0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = 32'd0;
  assign M_AXI_WSTRB   = 4'd0;
  assign M_AXI_WVALID  = 1'b0;
  assign M_AXI_BREADY  = 1'b1;

  assign dbg_state = state;

endmodule

// File: tb/tb_axi_revision_reader.sv
// tb_axi_revision_reader
// Drives the reader against a behavioural AXI4-Lite slave with configurable
// AR/R wait states and error injection. Expected AR addresses and the expected
// completed snapshot are queued at start time from the register map; a monitor
// pops and compares on every AR handshake and every done pulse.
module tb_axi_revision_reader;

  localparam int          AW     = 7;
  localparam int unsigned BASE   = 0;
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  typedef struct packed {
    logic         err;
    logic [415:0] words;
  } snap_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic          start;
  logic          busy, done, info_valid, resp_err;
  logic [31:0]   ver_major, ver_minor, ver_build, ver_rcand;
  logic [31:0]   build_date, build_time, rtl_type, rtl_subtype;
  logic [159:0]  git_hash;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic [2:0]    arprot;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic [2:0]    awprot;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          bready;
  logic [1:0]    dbg_state;

  axi_revision_reader #(.BASE_ADDR(BASE), .AW(AW)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n), .start(start),
    .busy(busy), .done(done), .info_valid(info_valid), .resp_err(resp_err),
    .ver_major(ver_major), .ver_minor(ver_minor), .ver_build(ver_build),
    .ver_rcand(ver_rcand), .build_date(build_date), .build_time(build_time),
    .rtl_type(rtl_type), .rtl_subtype(rtl_subtype), .git_hash(git_hash),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARPROT(arprot),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWPROT(awprot),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_BREADY(bready), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   reg_file [32];
  int            ar_dly, r_dly, err_idx;
  logic [1:0]    err_resp;
  int            ar_count = 0;
  logic [AW-1:0] exp_q[$];
  snap_t         snap_q[$];
  logic          prev_done = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input snap_t s, input int k);
    return s.words[k*32 +: 32];
  endfunction

  task automatic default_regs();
    for (int i = 0; i < 32; i++) reg_file[i] = 32'hDEAD_0000 + i;
    reg_file[0] = 32'd1;           reg_file[1] = 32'd2;
    reg_file[2] = 32'd3;           reg_file[3] = 32'd0;
    reg_file[4] = 32'h0605_2025;   reg_file[5] = 32'd5;
    reg_file[6] = 32'd6;           reg_file[7] = 32'h0014_3000;
    reg_file[16] = 32'h1111_1111;  reg_file[17] = 32'h2222_2222;
    reg_file[18] = 32'h3333_3333;  reg_file[19] = 32'h4444_4444;
    reg_file[20] = 32'h5555_5555;
  endtask

  // Reference model: the sequence reads register indices 0..20 except 8..15,
  // in ascending order; the snapshot holds each value as the slave returns it.
  task automatic issue_start();
    snap_t       s;
    int          k;
    logic [31:0] full;
    logic [31:0] w;
    s = '0;
    k = 0;
    for (int idx = 0; idx <= 20; idx++) begin
      if (idx > 7 && idx < 16) continue;
      full = BASE + 4 * idx;
      exp_q.push_back(full[AW-1:0]);
      w = reg_file[idx];
      if (idx == err_idx) begin
        s.err = 1'b1;
        if (err_resp == 2'b11) w = 32'd0;
      end
      s.words[k*32 +: 32] = w;
      k++;
    end
    snap_q.push_back(s);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got done=%0b after %0d cycles expected 1", done, n);
    end
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
  endtask

  task automatic wait_ar(input int target);
    int n;
    n = 0;
    while (ar_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ar_count < target) begin
      errors++;
      $display("FAIL ar_wait: got %0d handshakes expected %0d", ar_count, target);
    end
  endtask

  task automatic run_seq();
    issue_start();
    wait_done(3000);
  endtask

  // ---------------- slave model ----------------
  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] off;
    int            idx;
    bit            ok;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    forever begin
      @(posedge clk); #1;
      if (!(rst_n === 1'b1 && arvalid === 1'b1)) continue;
      a = araddr;
      for (int i = 0; i < ar_dly; i++) begin
        @(posedge clk); #1;
        if (!rst_n) break;
        check("arvalid_hold", arvalid, 1'b1);
        check("araddr_hold", araddr, a);
        check("rready_before_ar", rready, 1'b0);
      end
      arready = 1'b1;
      @(negedge clk);
      ok = (rst_n === 1'b1) && (arvalid === 1'b1);
      @(posedge clk); #1 arready = 1'b0;
      if (!ok) continue;
      off = a - BASE_A;
      idx = int'(off) >> 2;
      for (int i = 0; i < r_dly; i++) begin
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      if (idx == err_idx) begin
        rresp = err_resp;
        rdata = (err_resp == 2'b11) ? 32'd0 : reg_file[idx];
      end else begin
        rresp = 2'b00;
        rdata = reg_file[idx];
      end
      forever begin
        @(negedge clk);
        if (!rst_n) break;
        if (rready) begin
          @(posedge clk);
          break;
        end
      end
      #1 rvalid = 1'b0; rdata = '0; rresp = '0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    snap_t s;
    if (rst_n === 1'b1) begin
      if (arvalid && arready) begin
        ar_count++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ar: got addr 0x%0h expected no read", araddr);
        end else begin
          check("ar_addr", araddr, exp_q.pop_front());
        end
      end
      if (done) begin
        check("done_not_repeated", prev_done, 1'b0);
        if (snap_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          s = snap_q.pop_front();
          check("ver_major",   ver_major,   word_of(s, 0));
          check("ver_minor",   ver_minor,   word_of(s, 1));
          check("ver_build",   ver_build,   word_of(s, 2));
          check("ver_rcand",   ver_rcand,   word_of(s, 3));
          check("build_date",  build_date,  word_of(s, 4));
          check("rtl_type",    rtl_type,    word_of(s, 5));
          check("rtl_subtype", rtl_subtype, word_of(s, 6));
          check("build_time",  build_time,  word_of(s, 7));
          check("git_hash", git_hash, {word_of(s, 8), word_of(s, 9), word_of(s, 10),
                                       word_of(s, 11), word_of(s, 12)});
          check("info_valid_at_done", info_valid, 1'b1);
          check("resp_err_at_done", resp_err, s.err);
          check("busy_at_done", busy, 1'b0);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- global time bound ----------------
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before bound");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   c0;
    int   k;
    logic all_out;
    rst_n = 1'b0; start = 1'b0;
    ar_dly = 0; r_dly = 0; err_idx = -1; err_resp = 2'b11;
    default_regs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {arvalid, rready, busy, done, info_valid, resp_err}, '0);
    all_out = |{ver_major, ver_minor, ver_build, ver_rcand, build_date, build_time,
                rtl_type, rtl_subtype, git_hash, araddr};
    check("reset_data", all_out, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    check("tieoff_write", {awaddr, awvalid, awprot, wdata, wstrb, wvalid, arprot}, '0);
    check("tieoff_bready", bready, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait slave, default register contents.
    run_seq();
    check("git_hash_const", git_hash, 160'h11111111_22222222_33333333_44444444_55555555);
    check("ver_major_const", ver_major, 32'd1);

    // AR and R wait states.
    ar_dly = 5; r_dly = 3;
    run_seq();
    check("git_hash_const_wait", git_hash, 160'h11111111_22222222_33333333_44444444_55555555);

    // DECERR on index 16 only.
    ar_dly = 0; r_dly = 0; err_idx = 16; err_resp = 2'b11;
    run_seq();
    check("decerr_hash_w0", git_hash[159:128], 32'd0);
    check("decerr_resp_err", resp_err, 1'b1);

    // Re-read with MINOR changed; snapshot marked incoherent right after start.
    err_idx = -1; reg_file[1] = 32'd9;
    issue_start();
    @(negedge clk);
    check("info_valid_drop", info_valid, 1'b0);
    check("resp_err_cleared", resp_err, 1'b0);
    check("busy_after_start", busy, 1'b1);
    wait_done(3000);
    check("ver_minor_9", ver_minor, 32'd9);

    // start while busy at index 4 must not restart.
    ar_dly = 2; r_dly = 1;
    c0 = ar_count;
    issue_start();
    wait_ar(c0 + 5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(3000);
    repeat (20) @(negedge clk);
    check("reads_total", ar_count - c0, 13);
    check("exp_q_empty", exp_q.size(), 0);

    // Reset during the DATA phase of index 7.
    ar_dly = 0; r_dly = 4;
    c0 = ar_count;
    issue_start();
    wait_ar(c0 + 8);
    @(negedge clk);
    check("in_data_rready", rready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {arvalid, rready, busy, info_valid, done}, '0);
    all_out = |{ver_major, ver_minor, ver_build, ver_rcand, build_date, build_time,
                rtl_type, rtl_subtype, git_hash, araddr};
    check("midrst_data", all_out, 1'b0);
    exp_q.delete();
    snap_q.delete();
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    r_dly = 0;
    repeat (2) @(negedge clk);
    run_seq();

    // Randomized contents, wait states and error placement.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) reg_file[i] = $urandom;
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      err_resp = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 2) == 0) begin
        err_idx = -1;
      end else begin
        k = $urandom_range(0, 12);
        err_idx = (k < 8) ? k : k + 8;
      end
      run_seq();
    end
    repeat (5) @(negedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_snap_q_empty", snap_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
